// File: rtl/wb_stage_if.sv
// MEM->WB pipeline bus: one instruction's worth of fields presented by the MEM stage.
// The MEM stage (or a testbench) drives the master side; wb_stage consumes the slave side.
interface wb_stage_if;
  logic        mem_valid;
  logic        mem_regwrite;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wbsel;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_load_data;
  logic [31:0] mem_pc4;
  logic [31:0] mem_imm;

  modport master (
    output mem_valid, mem_regwrite, mem_rd, mem_wbsel, mem_funct3,
           mem_alu_result, mem_load_data, mem_pc4, mem_imm
  );

  modport slave (
    input  mem_valid, mem_regwrite, mem_rd, mem_wbsel, mem_funct3,
           mem_alu_result, mem_load_data, mem_pc4, mem_imm
  );
endinterface

// File: rtl/wb_stage.sv
// RV32I writeback stage: MEM/WB register, load extraction, result mux, retire counter.
// Optional same-cycle write-to-read bypass when WB_BYPASS_EN is defined.
module wb_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  wb_stage_if.slave   mem,
  output logic [4:0]  writereg,
  output logic [31:0] writedata,
  output logic        regwrite,
  output logic        load_misaligned,
  output logic [31:0] instret,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] readdata1_in,
  input  logic [31:0] readdata2_in,
  output logic [31:0] op1,
  output logic [31:0] op2
);

  localparam logic [1:0] WBSEL_ALU  = 2'b00;
  localparam logic [1:0] WBSEL_LOAD = 2'b01;
  localparam logic [1:0] WBSEL_PC4  = 2'b10;
  localparam logic [1:0] WBSEL_IMM  = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic        valid_q, valid_d;
  logic        regwrite_q, regwrite_d;
  logic [4:0]  rd_q, rd_d;
  logic [1:0]  wbsel_q, wbsel_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic [31:0] load_data_q, load_data_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] imm_q, imm_d;
  logic [31:0] instret_q, instret_d;

  logic        retire;
  logic        misaligned;
  logic [1:0]  offset;
  logic [7:0]  ld_lane [4];
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_value;

  // Flush only needs to kill valid; the other fields are left as-is.
  always_comb begin
    valid_d      = valid_q;
    regwrite_d   = regwrite_q;
    rd_d         = rd_q;
    wbsel_d      = wbsel_q;
    funct3_d     = funct3_q;
    alu_result_d = alu_result_q;
    load_data_d  = load_data_q;
    pc4_d        = pc4_q;
    imm_d        = imm_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      valid_d      = mem.mem_valid;
      regwrite_d   = mem.mem_regwrite;
      rd_d         = mem.mem_rd;
      wbsel_d      = mem.mem_wbsel;
      funct3_d     = mem.mem_funct3;
      alu_result_d = mem.mem_alu_result;
      load_data_d  = mem.mem_load_data;
      pc4_d        = mem.mem_pc4;
      imm_d        = mem.mem_imm;
    end
  end

  assign retire    = valid_q & ~stall & ~flush & ~load_misaligned;
  assign instret_d = retire ? instret_q + 32'd1 : instret_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      regwrite_q   <= 1'b0;
      rd_q         <= 5'd0;
      wbsel_q      <= 2'b00;
      funct3_q     <= 3'b000;
      alu_result_q <= 32'd0;
      load_data_q  <= 32'd0;
      pc4_q        <= 32'd0;
      imm_q        <= 32'd0;
      instret_q    <= 32'd0;
    end else begin
      valid_q      <= valid_d;
      regwrite_q   <= regwrite_d;
      rd_q         <= rd_d;
      wbsel_q      <= wbsel_d;
      funct3_q     <= funct3_d;
      alu_result_q <= alu_result_d;
      load_data_q  <= load_data_d;
      pc4_q        <= pc4_d;
      imm_q        <= imm_d;
      instret_q    <= instret_d;
    end
  end

  // Little-endian byte lanes of the raw memory word.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign ld_lane[gi] = load_data_q[8*gi +: 8];
  end

  assign offset  = alu_result_q[1:0];
  assign ld_byte = ld_lane[offset];
  assign ld_half = offset[1] ? load_data_q[31:16] : load_data_q[15:0];

  always_comb begin
    ld_value = 32'd0;
    case (funct3_q)
      F3_LB:   ld_value = {{24{ld_byte[7]}}, ld_byte};
      F3_LBU:  ld_value = {24'd0, ld_byte};
      F3_LH:   ld_value = {{16{ld_half[15]}}, ld_half};
      F3_LHU:  ld_value = {16'd0, ld_half};
      F3_LW:   ld_value = load_data_q;
      default: ld_value = 32'd0;
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    case (funct3_q)
      F3_LH, F3_LHU: misaligned = offset[0];
      F3_LW:         misaligned = (offset != 2'b00);
      F3_LB, F3_LBU: misaligned = 1'b0;
      default:       misaligned = 1'b1;
    endcase
  end

  assign load_misaligned = valid_q & (wbsel_q == WBSEL_LOAD) & misaligned;

  always_comb begin
    writedata = alu_result_q;
    case (wbsel_q)
      WBSEL_ALU:  writedata = alu_result_q;
      WBSEL_LOAD: writedata = ld_value;
      WBSEL_PC4:  writedata = pc4_q;
      WBSEL_IMM:  writedata = imm_q;
      default:    writedata = alu_result_q;
    endcase
  end

  assign regwrite = valid_q & regwrite_q & (rd_q != 5'd0) & ~load_misaligned;
  assign writereg = rd_q;
  assign instret  = instret_q;

`ifdef WB_BYPASS_EN
  // regwrite already excludes rd=0, so x0 reads are never forwarded.
  assign op1 = (regwrite && (writereg == rs1)) ? writedata : readdata1_in;
  assign op2 = (regwrite && (writereg == rs2)) ? writedata : readdata2_in;
`else
  logic unused_rs;
  assign unused_rs = ^{rs1, rs2};
  assign op1 = readdata1_in;
  assign op2 = readdata2_in;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Randomized self-checking bench for wb_stage against a behavioural writeback model.
// Honours WB_BYPASS_EN the same way the design does.
module tb_wb_stage;
  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [4:0]  writereg;
  logic [31:0] writedata;
  logic        regwrite;
  logic        load_misaligned;
  logic [31:0] instret;
  logic [4:0]  rs1, rs2;
  logic [31:0] readdata1_in, readdata2_in;
  logic [31:0] op1, op2;

  wb_stage_if bus ();

  wb_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .flush           (flush),
    .mem             (bus.slave),
    .writereg        (writereg),
    .writedata       (writedata),
    .regwrite        (regwrite),
    .load_misaligned (load_misaligned),
    .instret         (instret),
    .rs1             (rs1),
    .rs2             (rs2),
    .readdata1_in    (readdata1_in),
    .readdata2_in    (readdata2_in),
    .op1             (op1),
    .op2             (op2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // Reference model: the instruction currently sitting in writeback.
  bit          m_valid, m_rw, m_known;
  int unsigned m_rd, m_wbsel, m_f3;
  logic [31:0] m_alu, m_ld, m_pc4, m_imm, m_instret;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic bit m_bad_load();
    int unsigned off = m_alu % 4;
    if (!m_valid || m_wbsel != 1) return 1'b0;
    case (m_f3)
      1, 5:    return (off % 2) != 0;
      2:       return off != 0;
      3, 6, 7: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_load_value();
    int unsigned off = m_alu % 4;
    logic [31:0] b = (m_ld >> (8 * off)) & 32'hFF;
    logic [31:0] h = (m_ld >> (16 * (off / 2))) & 32'hFFFF;
    case (m_f3)
      0:       return (b >= 128) ? b - 32'd256 : b;
      4:       return b;
      1:       return (h >= 32768) ? h - 32'd65536 : h;
      5:       return h;
      2:       return m_ld;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_result();
    case (m_wbsel)
      0:       return m_alu;
      1:       return m_load_value();
      2:       return m_pc4;
      default: return m_imm;
    endcase
  endfunction

  function automatic bit m_writes();
    return m_valid && m_rw && (m_rd != 0) && !m_bad_load();
  endfunction

  task automatic check_all();
    logic [31:0] e1, e2;
    check("regwrite", {31'd0, regwrite}, {31'd0, m_writes()});
    check("load_misaligned", {31'd0, load_misaligned}, {31'd0, m_bad_load()});
    check("instret", instret, m_instret);
    if (m_known) begin
      check("writereg", {27'd0, writereg}, m_rd);
      check("writedata", writedata, m_result());
    end
    e1 = (BYPASS && m_writes() && m_rd == rs1) ? m_result() : readdata1_in;
    e2 = (BYPASS && m_writes() && m_rd == rs2) ? m_result() : readdata2_in;
    check("op1", op1, e1);
    check("op2", op2, e2);
  endtask

  // One clock: drive inputs, advance the model at the edge, then compare.
  task automatic step(input bit r, input bit st, input bit fl, input bit v, input bit rw,
                      input logic [4:0] rd, input logic [1:0] ws, input logic [2:0] f3,
                      input logic [31:0] alu, input logic [31:0] ld,
                      input logic [31:0] p4, input logic [31:0] im);
    rst = r; stall = st; flush = fl;
    bus.mem_valid = v; bus.mem_regwrite = rw; bus.mem_rd = rd; bus.mem_wbsel = ws;
    bus.mem_funct3 = f3; bus.mem_alu_result = alu; bus.mem_load_data = ld;
    bus.mem_pc4 = p4; bus.mem_imm = im;
    @(posedge clk);
    if (r) begin
      m_valid = 0; m_rw = 0; m_rd = 0; m_wbsel = 0; m_f3 = 0;
      m_alu = 0; m_ld = 0; m_pc4 = 0; m_imm = 0; m_instret = 0; m_known = 1;
    end else begin
      if (m_valid && !st && !fl && !m_bad_load()) m_instret = m_instret + 1;
      if (fl) begin
        m_valid = 0; m_known = 0;
      end else if (!st) begin
        m_valid = v; m_rw = rw; m_rd = rd; m_wbsel = ws; m_f3 = f3;
        m_alu = alu; m_ld = ld; m_pc4 = p4; m_imm = im; m_known = 1;
      end
    end
    #1;
    rs1 = ($urandom_range(0, 1) == 1) ? m_rd[4:0] : 5'($urandom_range(0, 31));
    rs2 = ($urandom_range(0, 1) == 1) ? m_rd[4:0] : 5'($urandom_range(0, 31));
    readdata1_in = $urandom;
    readdata2_in = $urandom;
    #1;
    check_all();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
  endtask

  initial begin
    logic [31:0] ic0;
    rst = 1; stall = 0; flush = 0;
    rs1 = 0; rs2 = 0; readdata1_in = 0; readdata2_in = 0;
    bus.mem_valid = 0; bus.mem_regwrite = 0; bus.mem_rd = 0; bus.mem_wbsel = 0;
    bus.mem_funct3 = 0; bus.mem_alu_result = 0; bus.mem_load_data = 0;
    bus.mem_pc4 = 0; bus.mem_imm = 0;

    step(1, 0, 0, 0, 0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    $display("txn reset");
    check("rst_regwrite", {31'd0, regwrite}, 32'd0);
    check("rst_writereg", {27'd0, writereg}, 32'd0);
    check("rst_writedata", writedata, 32'd0);
    check("rst_misaligned", {31'd0, load_misaligned}, 32'd0);
    check("rst_instret", instret, 32'd0);

    step(0, 0, 0, 1, 1, 5'd5, 2'b00, 3'd0, 32'h1234, 32'd0, 32'd0, 32'd0);
    $display("txn alu rd=5 data=%08h", writedata);
    check("alu_regwrite", {31'd0, regwrite}, 32'd1);
    check("alu_writereg", {27'd0, writereg}, 32'd5);
    check("alu_writedata", writedata, 32'h0000_1234);
    idle();
    check("alu_instret", instret, 32'd1);

    step(0, 0, 0, 1, 1, 5'd3, 2'b01, 3'b000, 32'h1003, 32'h80FF_0000, 32'd0, 32'd0);
    $display("txn lb data=%08h", writedata);
    check("lb_data", writedata, 32'hFFFF_FF80);
    step(0, 0, 0, 1, 1, 5'd3, 2'b01, 3'b100, 32'h1003, 32'h80FF_0000, 32'd0, 32'd0);
    $display("txn lbu data=%08h", writedata);
    check("lbu_data", writedata, 32'h0000_0080);
    step(0, 0, 0, 1, 1, 5'd3, 2'b01, 3'b101, 32'h1002, 32'hBEEF_0000, 32'd0, 32'd0);
    $display("txn lhu data=%08h", writedata);
    check("lhu_data", writedata, 32'h0000_BEEF);

    step(0, 0, 0, 1, 1, 5'd4, 2'b01, 3'b010, 32'h1002, 32'h1111_2222, 32'd0, 32'd0);
    $display("txn lw misaligned=%0d", load_misaligned);
    check("lw_mis", {31'd0, load_misaligned}, 32'd1);
    check("lw_regwrite", {31'd0, regwrite}, 32'd0);
    ic0 = instret;
    step(0, 0, 0, 1, 1, 5'd4, 2'b01, 3'b011, 32'h1000, 32'h1111_2222, 32'd0, 32'd0);
    $display("txn f3=011 misaligned=%0d", load_misaligned);
    check("lw_instret_hold", instret, ic0);
    check("f3_011_mis", {31'd0, load_misaligned}, 32'd1);
    check("f3_011_regwrite", {31'd0, regwrite}, 32'd0);
    ic0 = instret;

    step(0, 0, 0, 1, 1, 5'd0, 2'b10, 3'd0, 32'd0, 32'd0, 32'h40, 32'd0);
    $display("txn rd0 pc4 regwrite=%0d", regwrite);
    check("rd0_regwrite", {31'd0, regwrite}, 32'd0);
    check("rd0_instret_hold", instret, ic0);
    idle();
    check("rd0_instret_inc", instret, ic0 + 32'd1);

    step(0, 0, 0, 1, 1, 5'd9, 2'b00, 3'd0, 32'hCAFE, 32'd0, 32'd0, 32'd0);
    ic0 = instret;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 1, 1, 5'($urandom_range(1, 31)), 2'b00, 3'd0, $urandom, 32'd0, 32'd0, 32'd0);
      $display("txn stall %0d regwrite=%0d data=%08h", i, regwrite, writedata);
      check("stall_regwrite", {31'd0, regwrite}, 32'd1);
      check("stall_data", writedata, 32'hCAFE);
      check("stall_instret", instret, ic0);
    end
    idle();
    check("stall_release_instret", instret, ic0 + 32'd1);

    step(0, 0, 0, 1, 1, 5'd10, 2'b00, 3'd0, 32'h55, 32'd0, 32'd0, 32'd0);
    step(0, 1, 1, 1, 1, 5'd11, 2'b00, 3'd0, 32'h66, 32'd0, 32'd0, 32'd0);
    $display("txn flush+stall regwrite=%0d", regwrite);
    check("flush_regwrite", {31'd0, regwrite}, 32'd0);

    step(0, 0, 0, 1, 1, 5'd12, 2'b11, 3'd0, 32'd0, 32'd0, 32'd0, 32'h1234_5000);
    step(1, 1, 0, 1, 1, 5'd12, 2'b11, 3'd0, 32'd0, 32'd0, 32'd0, 32'h1234_5000);
    $display("txn reset-in-stall regwrite=%0d instret=%0d", regwrite, instret);
    check("rst_stall_regwrite", {31'd0, regwrite}, 32'd0);
    check("rst_stall_instret", instret, 32'd0);

    step(0, 0, 0, 1, 1, 5'd7, 2'b00, 3'd0, 32'hA5A5_A5A5, 32'd0, 32'd0, 32'd0);
    rs1 = 5'd7; readdata1_in = 32'd0;
    #1;
    $display("txn bypass op1=%08h", op1);
    check("bypass_op1", op1, BYPASS ? 32'hA5A5_A5A5 : 32'd0);

    for (int i = 0; i < 2000; i++) begin
      logic [31:0] alu;
      alu = $urandom;
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 80,
           ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
           2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
           alu, $urandom, $urandom, $urandom);
      $display("txn rand %0d rw=%0d rd=%0d wd=%08h mis=%0d ir=%0d",
               i, regwrite, writereg, writedata, load_misaligned, instret);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
